stopwatch_ctrl: RTL

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_pkg.sv | 39 +++
 rtl/key_debounce.sv | 57 +++++
 rtl/stopwatch_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared encodings and sizing for the stopwatch controller and its key front end.
package stopwatch_pkg;

  localparam int MAX_COUNT         = 600000;
  localparam int CNT_W             = $clog2(MAX_COUNT);
  localparam int DEB_TICKS_DEFAULT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_LAP   = 2'b11
  } state_e;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_PAS,
    CMD_RST,
    CMD_STR,
    CMD_LAP
  } cmd_e;

  typedef struct packed {
    logic str;
    logic pas;
    logic lap;
    logic rst;
  } keys_t;

  // Same-cycle presses collapse to the single highest-priority command.
  function automatic cmd_e pick_cmd(input keys_t p);
    if (p.pas) return CMD_PAS;
    if (p.rst) return CMD_RST;
    if (p.str) return CMD_STR;
    if (p.lap) return CMD_LAP;
    return CMD_NONE;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One raw active-low key: 2-flop synchronizer, level debouncer, and a
// single-cycle press pulse when a stable low level is accepted.
module key_debounce #(
  parameter int DEB_TICKS = 2
) (
  input  logic clk_10ms,
  input  logic clr,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEB_TICKS + 1);

  logic          sync1_q, sync2_q;
  logic          armed_q, armed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchronizer into one stage.
  always_ff @(posedge clk_10ms or negedge clr) begin
    if (!clr) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      armed_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  // Armed waits for a stable low, disarmed waits for a stable high; in both
  // cases the interesting sample is the one that differs from armed_q.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    cnt_d   = '0;
    armed_d = armed_q;
    press_d = 1'b0;
    if (sync2_q != armed_q) begin
      if (cnt_q == CW'(DEB_TICKS - 1)) begin
        armed_d = ~armed_q;
        press_d = armed_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: debounced keys drive IDLE/RUN/PAUSE/LAP, timer
// enable/clear, and the lap capture register. All outputs are registered.
module stopwatch_ctrl #(
  parameter int DEB_TICKS = stopwatch_pkg::DEB_TICKS_DEFAULT,
  parameter int CNT_W     = stopwatch_pkg::CNT_W
) (
  input  logic             clk_10ms,
  input  logic             clr,
  input  logic [1:0]       en,
  input  logic             key_str,
  input  logic             key_pas,
  input  logic             key_lap,
  input  logic             key_rst,
  input  logic [CNT_W-1:0] count,
  output logic             run,
  output logic             cnt_clr_n,
  output logic [CNT_W-1:0] lap_val,
  output logic             lap_valid,
  output logic             disp_sel,
  output logic [1:0]       state
);

  import stopwatch_pkg::*;

  keys_t pulse;
  cmd_e  cmd;

  key_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_str (
    .clk_10ms(clk_10ms), .clr(clr), .key_n(key_str), .press(pulse.str));
  key_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_pas (
    .clk_10ms(clk_10ms), .clr(clr), .key_n(key_pas), .press(pulse.pas));
  key_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_lap (
    .clk_10ms(clk_10ms), .clr(clr), .key_n(key_lap), .press(pulse.lap));
  key_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_rst (
    .clk_10ms(clk_10ms), .clr(clr), .key_n(key_rst), .press(pulse.rst));

  state_e             state_q, state_d;
  logic               run_q, run_d;
  logic               cnt_clr_n_q, cnt_clr_n_d;
  logic [CNT_W-1:0]   lap_val_q, lap_val_d;
  logic               lap_valid_q, lap_valid_d;
  logic               disp_sel_q, disp_sel_d;

  always_comb begin
    cmd         = (en == 2'd1) ? pick_cmd(pulse) : CMD_NONE;
    state_d     = state_q;
    lap_val_d   = lap_val_q;
    lap_valid_d = lap_valid_q;
    cnt_clr_n_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd == CMD_STR) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (cmd == CMD_PAS) begin
          state_d = ST_PAUSE;
        end else if (cmd == CMD_LAP) begin
          state_d     = ST_LAP;
          lap_val_d   = count;
          lap_valid_d = 1'b1;
        end
      end
      ST_LAP: begin
        if (cmd == CMD_PAS) begin
          state_d = ST_PAUSE;
        end else if (cmd == CMD_STR) begin
          state_d = ST_RUN;
        end else if (cmd == CMD_LAP) begin
          lap_val_d   = count;
          lap_valid_d = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (cmd == CMD_STR) begin
          state_d = ST_RUN;
        end else if (cmd == CMD_RST) begin
          state_d     = ST_IDLE;
          lap_valid_d = 1'b0;
          cnt_clr_n_d = 1'b0;
        end
      end
    endcase

    // Outputs are decoded from the next state so they land on the same edge.
    run_d      = (state_d == ST_RUN) || (state_d == ST_LAP);
    disp_sel_d = (state_d == ST_LAP);
  end

  always_ff @(posedge clk_10ms or negedge clr) begin
    if (!clr) begin
      state_q     <= ST_IDLE;
      run_q       <= 1'b0;
      cnt_clr_n_q <= 1'b1;
      lap_val_q   <= '0;
      lap_valid_q <= 1'b0;
      disp_sel_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      cnt_clr_n_q <= cnt_clr_n_d;
      lap_val_q   <= lap_val_d;
      lap_valid_q <= lap_valid_d;
      disp_sel_q  <= disp_sel_d;
    end
  end

  assign state     = state_q;
  assign run       = run_q;
  assign cnt_clr_n = cnt_clr_n_q;
  assign lap_val   = lap_val_q;
  assign lap_valid = lap_valid_q;
  assign disp_sel  = disp_sel_q;

endmodule
